tt_um_uart_tx: RTL
==================

TT_UM_UART_TX -- requirements
Module: tt_um_uart_tx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..255.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port ena, input, 1 bit: design enable.
REQ-005 The module SHALL have port ui_in, input, 8 bits: byte to be written into the TX FIFO.
REQ-006 The module SHALL have port uo_out, output, 8 bits: [0] txd serial line, [3:1] FIFO count (0..4), [7:4] tied to 0.
REQ-007 The module SHALL have port uio_in, input, 8 bits: [0] wr (synchronous write enable, one byte per high cycle), [1] ovf_clr, [7:2] ignored.
REQ-008 The module SHALL have port uio_out, output, 8 bits: [3:0] tied to 0, [4] full, [5] empty, [6] busy, [7] overflow (sticky).
REQ-009 The module SHALL have port uio_oe, output, 8 bits, driven constant 8'hF0.

Function
REQ-010 The module SHALL contain a 4-entry first-in first-out byte buffer with a 3-bit occupancy count.
REQ-011 While ena=1 and wr=1 and count<4, the module SHALL store ui_in at the clock edge.
REQ-012 When wr=1 and count=4, the write SHALL be dropped and overflow SHALL be set, even if a pop occurs in the same cycle.
REQ-013 A simultaneous write and pop at count 1..3 SHALL leave count unchanged and preserve byte order.
REQ-014 overflow SHALL clear on the edge where ovf_clr=1; a new overflow in the same cycle SHALL win, leaving overflow at 1.
REQ-015 The transmit FSM SHALL have states IDLE, START, DATA, STOP.
REQ-016 IDLE->START SHALL occur on the edge where state=IDLE, count>0 and ena=1; the head byte SHALL be popped on that same edge.
REQ-017 txd SHALL be 0 for CLKS_PER_BIT cycles in START.
REQ-018 DATA SHALL shift out 8 bits LSB first, each bit held for CLKS_PER_BIT cycles.
REQ-019 txd SHALL be 1 for CLKS_PER_BIT cycles in STOP.
REQ-020 On the last STOP cycle, the FSM SHALL go to START with a pop if count>0 and ena=1, otherwise to IDLE; there SHALL be no idle gap between queued frames.
REQ-021 A frame SHALL be exactly 10*CLKS_PER_BIT cycles long.
REQ-022 txd SHALL be 1 in IDLE; txd SHALL be driven from a register, glitch-free.
REQ-023 busy SHALL be 1 in every state other than IDLE.
REQ-024 full SHALL be 1 exactly when count=4, and empty SHALL be 1 exactly when count=0.
REQ-025 Latency: a byte written at edge k into an empty FIFO while IDLE SHALL make txd fall at edge k+1.
REQ-026 While ena=0, writes SHALL be ignored and no new frame SHALL start; a frame already in progress SHALL complete normally.
REQ-027 The bit-cycle counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, SHALL count 0..CLKS_PER_BIT-1, and SHALL wrap at each bit boundary.

Reset
REQ-028 While rst_n=0, regardless of clk, the module SHALL force: state IDLE, txd=1, FIFO empty, count=0, overflow=0, shift register and bit counters 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately and discard all queued bytes.
REQ-030 After rst_n deasserts, uo_out SHALL read 8'h01 and uio_out SHALL read 8'h20.

Verification
REQ-031 Single byte (CLKS_PER_BIT=4): write 8'hA5 once -> txd reads 0,1,0,1,0,0,1,0,1,1 per 4-cycle bit (40 cycles total); busy falls after the 40th cycle.
REQ-032 Back-to-back: write 8'h00 then 8'hFF on consecutive cycles -> 80 contiguous frame cycles with no idle cycle between the two stop/start bits.
REQ-033 Overflow: while IDLE, hold wr=1 for 6 cycles with bytes 1..6 -> bytes 1..5 are transmitted in order; byte 6 is dropped; overflow=1 and full=1 after the 6th edge; a pulse on ovf_clr clears overflow.
REQ-034 Enable gating: with ena=0, write 8'h3C -> count stays 0 and txd stays 1. Separately, drop ena mid-frame with 2 bytes queued -> the current frame completes; the next frame starts only after ena returns to 1.
REQ-035 Reset mid-frame: assert rst_n=0 during a DATA bit with 3 bytes queued -> txd=1, count=0 and busy=0 immediately; after release, nothing is transmitted.

Source files
------------

// File: rtl/tt_um_uart_tx.sv
// 8N1 UART transmitter fed by a 4-entry byte FIFO, using the TinyTapeout pin layout.
// A queued byte starts its frame on the edge after it is written; queued frames go out back to back.
module tt_um_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shifter_reg, shifter_next;
  logic          txd_reg, txd_next;

  logic [7:0] fifo_mem [0:3];
  logic [1:0] wr_ptr_reg, rd_ptr_reg;
  logic [2:0] count_reg, count_next;
  logic       ovf_reg, ovf_next;

  logic       wr_req, wr_en, ovf_set, bit_end, pop;
  logic [7:0] head;
  logic       unused_ok;

  assign unused_ok = &{1'b0, uio_in[7:2]};

  assign wr_req  = ena & uio_in[0];
  assign wr_en   = wr_req & (count_reg != 3'd4);
  assign ovf_set = wr_req & (count_reg == 3'd4);
  assign bit_end = (clk_cnt_reg == LAST_CLK);
  assign head    = fifo_mem[rd_ptr_reg];

  // A pop and a frame start are the same event: from IDLE, or from the last STOP cycle.
  assign pop = ena & (count_reg != 3'd0) &
               ((state_reg == IDLE) | ((state_reg == STOP) & bit_end));

  assign count_next = count_reg + {2'b00, wr_en} - {2'b00, pop};
  assign ovf_next   = ovf_set ? 1'b1 : (uio_in[1] ? 1'b0 : ovf_reg);

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_idx_next = bit_idx_reg;
    shifter_next = shifter_reg;
    txd_next     = txd_reg;
    case (state_reg)
      IDLE: begin
        clk_cnt_next = '0;
        txd_next     = 1'b1;
        if (pop) begin
          state_next   = START;
          shifter_next = head;
          txd_next     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          bit_idx_next = 3'd0;
          state_next   = DATA;
          txd_next     = shifter_reg[0];
          shifter_next = shifter_reg >> 1;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
            txd_next   = 1'b1;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            txd_next     = shifter_reg[0];
            shifter_next = shifter_reg >> 1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_next = '0;
          if (pop) begin
            state_next   = START;
            shifter_next = head;
            txd_next     = 1'b0;
          end else begin
            state_next = IDLE;
            txd_next   = 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        clk_cnt_next = '0;
        txd_next     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= 3'd0;
      shifter_reg <= 8'd0;
      txd_reg     <= 1'b1;
      wr_ptr_reg  <= 2'd0;
      rd_ptr_reg  <= 2'd0;
      count_reg   <= 3'd0;
      ovf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shifter_reg <= shifter_next;
      txd_reg     <= txd_next;
      count_reg   <= count_next;
      ovf_reg     <= ovf_next;
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 2'd1;
    end
  end

  // Storage needs no reset: entries are only read once the count says they were written.
  always_ff @(posedge clk) begin
    if (wr_en) fifo_mem[wr_ptr_reg] <= ui_in;
  end

  assign uo_out  = {4'b0000, count_reg, txd_reg};
  assign uio_out = {ovf_reg, (state_reg != IDLE), (count_reg == 3'd0), (count_reg == 3'd4), 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
